audio_mixer: RTL and testbench
==============================

// Module: audio_mixer
// PURPOSE
//  Downstream of the AY PSG. Mixes PSG channels A/B/C with the ULA beeper (speaker, EAR, MIC)
//  into left/right 14-bit unsigned PCM, with mono/ABC/ACB stereo modes.
//  Drives a first-order 1-bit sigma-delta DAC per side for the board audio pins.
//  PCM outputs also feed any later I2S/HDMI audio stage.
// PARAMETERS
//  SPK_LEVEL  14'h1000  amplitude added when spk=1
//  EAR_LEVEL  14'h0800  amplitude added when ear=1
//  MIC_LEVEL  14'h0200  amplitude added when mic=1
// PORTS
//  clock   in   1   system clock
//  reset   in   1   asynchronous, active-low reset
//  ce      in   1   sample enable; input capture strobe (same ce that drives the PSG)
//  mode    in   2   00 mono, 01 ABC, 10 ACB, 11 PSG muted (beeper only)
//  a       in   12  PSG channel A level, unsigned
//  b       in   12  PSG channel B level, unsigned
//  c       in   12  PSG channel C level, unsigned
//  spk     in   1   ULA speaker bit
//  ear     in   1   tape input bit (monitor)
//  mic     in   1   ULA MIC output bit
//  left    out  14  mixed left PCM, unsigned
//  right   out  14  mixed right PCM, unsigned
//  dsl     out  1   left sigma-delta bitstream
//  dsr     out  1   right sigma-delta bitstream
// BEHAVIOUR
//  Reset (reset=0, async): every register clears; left=right=0, dsl=dsr=0, accumulators=0.
//  Stage 1: on posedge clock with ce=1, register a, b, c, spk, ear, mic and mode.
//   With ce=0 they hold.
//  Stage 2: every posedge clock (not ce-gated), compute the following from the stage-1 registers.
//   Register the result into left/right.
//   Latency: an input captured at ce edge N appears on left/right at edge N+1.
//  PSG terms (x/2 = x>>1, truncating; sums held 16 bits wide):
//   mono: L = R = a/2 + b/2 + c/2
//   ABC:  L = a + b/2, R = c + b/2
//   ACB:  L = a + c/2, R = b + c/2
//   11:   L = R = 0
//  Beeper term, added to both sides: spk?SPK_LEVEL:0 + ear?EAR_LEVEL:0 + mic?MIC_LEVEL:0.
//  Saturation: if the 16-bit sum exceeds 16383, output 14'h3FFF. No wrap-around allowed.
//   With default levels the max is 6142+6656=12798, so no clipping occurs.
//  Sigma-delta, per side, every clock (not ce-gated), 15-bit accumulator acc:
//   acc <= {1'b0, acc[13:0]} + {1'b0, pcm}; bitstream bit = acc[14] (registered).
//   The pcm input is the registered left/right, so the bitstream lags PCM by one clock.
//   Ones density = pcm/16384; pcm=0 gives a constant 0.
//  A mode change takes effect with the next ce capture; it never glitches mid-sample.
//  Reset mid-operation: everything clears immediately. Outputs stay 0 until the first ce
//   after release, plus one clock.
// STRUCTURE
//  Shared package (audio_pkg): MODE_MONO/MODE_ABC/MODE_ACB/MODE_MUTE encodings;
//   default SPK/EAR/MIC levels; PCM_W=14.
//  Sub-module sigma_delta_dac (params W=14; ports clock, reset, pcm[W-1:0], q).
//   Instantiated twice, once per side.
//  Mixer and saturation are inline in audio_mixer.
// TESTING
//  1. Reset: hold reset=0 with random inputs -> left=right=0, dsl=dsr=0.
//     After release with inputs still 0 -> all outputs remain 0.
//  2. ABC: mode=01, a=12'hFFF, b=12'h800, c=0, one ce pulse.
//     -> one clock later left=4095+1024=5119, right=1024.
//  3. ACB/mono: a=100, b=200, c=300.
//     ACB -> L=250, R=350. Mono -> L=R=50+100+150=300.
//     Inputs changed while ce=0 -> outputs unchanged.
//  4. Beeper with mute: mode=11, a=b=c=12'hFFF, spk=ear=mic=1 -> L=R=4096+2048+512=6656.
//     Then with SPK_LEVEL=14'h3000, mode=01, a=b=c=12'hFFF -> L=R=16383 (saturated).
//  5. Sigma-delta: force left=8192 -> dsl alternates 0101... with density 0.5 over 1024 clocks.
//     left=4096 -> exactly 256 ones in 1024 clocks. left=0 -> no ones.
//  6. Mid-run reset: assert reset during steady pcm=8192 -> dsl/left drop to 0 asynchronously.
//     After release, bitstream density recovers to within ±1 count over 64 clocks.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio mixer: stereo mode encodings, default beeper
// levels and the PCM width, plus the 14-bit saturation helper.
package audio_pkg;

    localparam int PCM_W = 14;

    typedef enum logic [1:0] {
        MODE_MONO = 2'b00,
        MODE_ABC  = 2'b01,
        MODE_ACB  = 2'b10,
        MODE_MUTE = 2'b11
    } mode_t;

    localparam logic [PCM_W-1:0] DEFAULT_SPK_LEVEL = 14'h1000;
    localparam logic [PCM_W-1:0] DEFAULT_EAR_LEVEL = 14'h0800;
    localparam logic [PCM_W-1:0] DEFAULT_MIC_LEVEL = 14'h0200;

    // Clamp a 16-bit mix sum to full scale instead of letting it wrap.
    function automatic logic [PCM_W-1:0] sat_pcm(input logic [15:0] sum);
        if (sum > 16'd16383)
            return 14'h3FFF;
        else
            return sum[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order 1-bit sigma-delta modulator: the accumulator carry is the output
// bit, so the ones density equals pcm / 2**W.
module sigma_delta_dac #(
    parameter int W = 14
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] pcm,
    output logic         q
);

    logic [W:0] acc;

    // The carry out of the previous step is dropped before the next add.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            acc <= '0;
        else
            acc <= {1'b0, acc[W-1:0]} + {1'b0, pcm};
    end

    assign q = acc[W];

endmodule

// File: rtl/audio_mixer.sv
// Mixes PSG channels A/B/C with the ULA beeper bits into saturated 14-bit
// left/right PCM and drives one sigma-delta DAC per side.
module audio_mixer
    import audio_pkg::*;
#(
    parameter logic [13:0] SPK_LEVEL = DEFAULT_SPK_LEVEL,
    parameter logic [13:0] EAR_LEVEL = DEFAULT_EAR_LEVEL,
    parameter logic [13:0] MIC_LEVEL = DEFAULT_MIC_LEVEL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  mode,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] c,
    input  logic        spk,
    input  logic        ear,
    input  logic        mic,
    output logic [13:0] left,
    output logic [13:0] right,
    output logic        dsl,
    output logic        dsr
);

    mode_t       mode_q;
    logic [11:0] a_q, b_q, c_q;
    logic        spk_q, ear_q, mic_q;

    logic [15:0] a_full, b_full, c_full;
    logic [15:0] a_half, b_half, c_half;
    logic [15:0] psg_l, psg_r, beep;
    logic [15:0] sum_l, sum_r;

    // Capture on the PSG sample strobe so a mode change only lands between samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_MONO;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            spk_q  <= 1'b0;
            ear_q  <= 1'b0;
            mic_q  <= 1'b0;
        end else if (ce) begin
            mode_q <= mode_t'(mode);
            a_q    <= a;
            b_q    <= b;
            c_q    <= c;
            spk_q  <= spk;
            ear_q  <= ear;
            mic_q  <= mic;
        end
    end

    assign a_full = {4'b0, a_q};
    assign b_full = {4'b0, b_q};
    assign c_full = {4'b0, c_q};
    assign a_half = {5'b0, a_q[11:1]};
    assign b_half = {5'b0, b_q[11:1]};
    assign c_half = {5'b0, c_q[11:1]};

    always_comb begin
        psg_l = '0;
        psg_r = '0;
        case (mode_q)
            MODE_MONO: begin
                psg_l = a_half + b_half + c_half;
                psg_r = a_half + b_half + c_half;
            end
            MODE_ABC: begin
                psg_l = a_full + b_half;
                psg_r = c_full + b_half;
            end
            MODE_ACB: begin
                psg_l = a_full + c_half;
                psg_r = b_full + c_half;
            end
            default: begin
                psg_l = '0;
                psg_r = '0;
            end
        endcase
    end

    assign beep  = (spk_q ? {2'b0, SPK_LEVEL} : 16'd0)
                 + (ear_q ? {2'b0, EAR_LEVEL} : 16'd0)
                 + (mic_q ? {2'b0, MIC_LEVEL} : 16'd0);
    assign sum_l = psg_l + beep;
    assign sum_r = psg_r + beep;

    // The output stage runs every clock so the DACs see a steady registered PCM value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left  <= '0;
            right <= '0;
        end else begin
            left  <= sat_pcm(sum_l);
            right <= sat_pcm(sum_r);
        end
    end

    sigma_delta_dac #(.W(PCM_W)) u_dac_left (
        .clock (clock),
        .reset (reset),
        .pcm   (left),
        .q     (dsl)
    );

    sigma_delta_dac #(.W(PCM_W)) u_dac_right (
        .clock (clock),
        .reset (reset),
        .pcm   (right),
        .q     (dsr)
    );

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: randomized mixes against an integer model,
// plus reset, hold, saturation and sigma-delta density scenarios.
module tb_audio_mixer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce    = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic [11:0] a = '0, b = '0, c = '0;
    logic        spk = 1'b0, ear = 1'b0, mic = 1'b0;
    logic [13:0] left, right, left_s, right_s;
    logic        dsl, dsr, dsl_s, dsr_s;

    int checks = 0;
    int passed = 0;

    audio_mixer dut (
        .clock(clock), .reset(reset), .ce(ce), .mode(mode),
        .a(a), .b(b), .c(c), .spk(spk), .ear(ear), .mic(mic),
        .left(left), .right(right), .dsl(dsl), .dsr(dsr)
    );

    audio_mixer #(.SPK_LEVEL(14'h3000)) dut_sat (
        .clock(clock), .reset(reset), .ce(ce), .mode(mode),
        .a(a), .b(b), .c(c), .spk(spk), .ear(ear), .mic(mic),
        .left(left_s), .right(right_s), .dsl(dsl_s), .dsr(dsr_s)
    );

    always #5 clock = ~clock;

    // Reference mix in plain integer arithmetic, clamped to full scale.
    function automatic int model_side(input int m, input int av, input int bv, input int cv,
                                      input int sp, input int ea, input int mi,
                                      input int spk_lvl, input bit rside);
        int psg;
        int total;
        case (m)
            0: psg = av / 2 + bv / 2 + cv / 2;
            1: psg = rside ? cv + bv / 2 : av + bv / 2;
            2: psg = rside ? bv + cv / 2 : av + cv / 2;
            default: psg = 0;
        endcase
        total = psg + sp * spk_lvl + ea * 2048 + mi * 512;
        return (total > 16383) ? 16383 : total;
    endfunction

    function automatic logic [13:0] exp_side(input bit rside, input int spk_lvl);
        return 14'(model_side(int'(mode), int'(a), int'(b), int'(c), int'(spk), int'(ear),
                              int'(mic), spk_lvl, rside));
    endfunction

    task automatic capture();
        ce = 1'b1;
        @(negedge clock);
        ce = 1'b0;
        @(negedge clock);
    endtask

    task automatic set_inputs(input logic [1:0] m, input logic [11:0] av, input logic [11:0] bv,
                              input logic [11:0] cv, input logic sp, input logic ea, input logic mi);
        mode = m; a = av; b = bv; c = cv; spk = sp; ear = ea; mic = mi;
    endtask

    task automatic count_ones(input int n, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ones_l += int'(dsl);
            ones_r += int'(dsr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_inputs(2'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clock);
        end
        checks++;
        if ({left, right, dsl, dsr} !== 30'd0)
            $display("[TB] FAIL reset_hold: left=%0d right=%0d dsl=%b dsr=%b, want all 0", left, right, dsl, dsr);
        else passed++;
        set_inputs(2'b00, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        ce = 1'b0;
        checks++;
        if ({left, right, dsl, dsr} !== 30'd0)
            $display("[TB] FAIL reset_release: left=%0d right=%0d dsl=%b dsr=%b, want all 0", left, right, dsl, dsr);
        else passed++;
    endtask

    task automatic test_directed_modes();
        set_inputs(2'b01, 12'hFFF, 12'h800, 12'h000, 1'b0, 1'b0, 1'b0);
        capture();
        checks++;
        if (left !== 14'd5119 || right !== 14'd1024)
            $display("[TB] FAIL abc_directed: left=%0d right=%0d, want 5119/1024", left, right);
        else passed++;
        set_inputs(2'b10, 12'd100, 12'd200, 12'd300, 1'b0, 1'b0, 1'b0);
        capture();
        checks++;
        if (left !== 14'd250 || right !== 14'd350)
            $display("[TB] FAIL acb_directed: left=%0d right=%0d, want 250/350", left, right);
        else passed++;
        mode = 2'b00;
        capture();
        checks++;
        if (left !== 14'd300 || right !== 14'd300)
            $display("[TB] FAIL mono_directed: left=%0d right=%0d, want 300/300", left, right);
        else passed++;
    endtask

    task automatic test_hold();
        logic [13:0] exp_l, exp_r;
        exp_l = left;
        exp_r = right;
        for (int i = 0; i < 8; i++) begin
            set_inputs(2'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clock);
        end
        checks++;
        if (left !== 14'd300 || right !== 14'd300)
            $display("[TB] FAIL hold_no_ce: left=%0d right=%0d, want %0d/%0d", left, right, exp_l, exp_r);
        else passed++;
    endtask

    task automatic test_random_mix();
        logic [13:0] el, er, esl, esr;
        int errs = 0;
        for (int i = 0; i < 40; i++) begin
            set_inputs(2'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
            if (i % 5 == 0) begin
                a = 12'hFFF; b = 12'hFFF; c = 12'hFFF;
            end
            el = exp_side(1'b0, 4096);
            er = exp_side(1'b1, 4096);
            esl = exp_side(1'b0, 12288);
            esr = exp_side(1'b1, 12288);
            capture();
            checks++;
            if (left !== el || right !== er || left_s !== esl || right_s !== esr) begin
                errs++;
                $display("[TB] FAIL random_mix[%0d] mode=%0d: got %0d/%0d sat %0d/%0d, want %0d/%0d sat %0d/%0d",
                         i, mode, left, right, left_s, right_s, el, er, esl, esr);
            end else passed++;
        end
    endtask

    task automatic test_beeper_saturation();
        set_inputs(2'b11, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b1, 1'b1);
        capture();
        checks++;
        if (left !== 14'd6656 || right !== 14'd6656)
            $display("[TB] FAIL beeper_mute: left=%0d right=%0d, want 6656/6656", left, right);
        else passed++;
        mode = 2'b01;
        capture();
        checks++;
        if (left_s !== 14'h3FFF || right_s !== 14'h3FFF)
            $display("[TB] FAIL saturation: left=%0d right=%0d, want 16383/16383", left_s, right_s);
        else passed++;
    endtask

    task automatic test_sigma_delta();
        int ol, orr;
        int prev;
        int toggles;
        int n;
        set_inputs(2'b01, 12'd4095, 12'd2, 12'd0, 1'b1, 1'b0, 1'b0);
        capture();
        repeat (4) @(negedge clock);
        checks++;
        if (left !== 14'd8192)
            $display("[TB] FAIL sd_setup_8192: left=%0d, want 8192", left);
        else passed++;
        prev = int'(dsl);
        toggles = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (int'(dsl) != prev) toggles++;
            prev = int'(dsl);
        end
        checks++;
        if (toggles != 16)
            $display("[TB] FAIL sd_alternate: toggles=%0d, want 16", toggles);
        else passed++;
        count_ones(1024, ol, orr);
        checks++;
        if (ol != 512)
            $display("[TB] FAIL sd_density_8192: ones=%0d, want 512", ol);
        else passed++;
        set_inputs(2'b11, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
        capture();
        repeat (4) @(negedge clock);
        count_ones(1024, ol, orr);
        checks++;
        if (ol != 256 || orr != 256)
            $display("[TB] FAIL sd_density_4096: ones=%0d/%0d, want 256/256", ol, orr);
        else passed++;
        spk = 1'b0;
        capture();
        repeat (4) @(negedge clock);
        count_ones(1024, ol, orr);
        checks++;
        if (ol != 0 || orr != 0)
            $display("[TB] FAIL sd_density_0: ones=%0d/%0d, want 0/0", ol, orr);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            set_inputs(2'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
            n = model_side(int'(mode), int'(a), int'(b), int'(c), int'(spk), int'(ear), int'(mic), 4096, 1'b1);
            capture();
            repeat (4) @(negedge clock);
            count_ones(1024, ol, orr);
            checks++;
            if (orr * 16384 - 1024 * n >= 16384 || 1024 * n - orr * 16384 >= 16384)
                $display("[TB] FAIL sd_density_random[%0d]: pcm=%0d ones=%0d, want about %0d", k, n, orr, (1024 * n) / 16384);
            else passed++;
        end
    endtask

    task automatic test_midrun_reset();
        int ol, orr;
        set_inputs(2'b01, 12'd4095, 12'd2, 12'd0, 1'b1, 1'b0, 1'b0);
        capture();
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (left !== 14'd0 || right !== 14'd0 || dsl !== 1'b0 || dsr !== 1'b0)
            $display("[TB] FAIL async_reset: left=%0d right=%0d dsl=%b dsr=%b, want all 0", left, right, dsl, dsr);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (left !== 14'd0 || dsl !== 1'b0)
            $display("[TB] FAIL reset_wait_ce: left=%0d dsl=%b, want 0/0", left, dsl);
        else passed++;
        capture();
        checks++;
        if (left !== 14'd8192)
            $display("[TB] FAIL reset_recover_pcm: left=%0d, want 8192", left);
        else passed++;
        count_ones(64, ol, orr);
        checks++;
        if (ol < 31 || ol > 33)
            $display("[TB] FAIL reset_recover_density: ones=%0d, want 32 +/- 1", ol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed_modes();
        test_hold();
        test_random_mix();
        test_beeper_saturation();
        test_sigma_delta();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
